alu_issue: RTL and testbench

- Requester-side front end of the combinational ALU.
- Accepts operation requests on a valid/ready interface and registers them.
- Drives the ALU operand/opcode inputs from that register, then captures the ALU result and zero flag into a response register on a second valid/ready interface.
- Two-stage pipeline with full backpressure, 1 op/cycle throughput. Screens illegal opcodes and divide-by-zero before results leave the block.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/pipe_stage.sv | 39 +++
 rtl/alu_issue.sv | 126 ++++++++++++
 tb/tb_alu_issue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, widths and pipeline payload types.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned DATA_W   = 32;

  localparam logic [ALU_OP_W-1:0] ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] MUL = 4'h2;
  localparam logic [ALU_OP_W-1:0] DIV = 4'h3;
  localparam logic [ALU_OP_W-1:0] AND = 4'h4;
  localparam logic [ALU_OP_W-1:0] OR  = 4'h5;
  localparam logic [ALU_OP_W-1:0] XOR = 4'h6;
  localparam logic [ALU_OP_W-1:0] NOT = 4'h7;
  localparam logic [ALU_OP_W-1:0] LEZ = 4'h8;
  localparam logic [ALU_OP_W-1:0] LTZ = 4'h9;
  localparam logic [ALU_OP_W-1:0] GTZ = 4'hA;
  localparam logic [ALU_OP_W-1:0] EQT = 4'hB;
  localparam logic [ALU_OP_W-1:0] NET = 4'hC;

  localparam logic [ALU_OP_W-1:0] OP_LAST = 4'hC;

  // Issue stage payload (tag is carried alongside, its width is a top parameter)
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } issue_t;

  // Response stage payload after error screening
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err;
  } resp_t;

endpackage

// File: rtl/pipe_stage.sv
// Single valid/ready register slice with synchronous reset and flush.
// Payload resets to zero; flush only clears the valid bit.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Slice register: load on accept, hold payload otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Requester-side front end of the combinational ALU: issue register drives
// the ALU, response register captures the screened result.
// Optional build macro: ALU_ISSUE_STATS_EN adds handshake/error counters.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned       TAG_W       = 4,
  parameter logic [DATA_W-1:0] DIV0_RESULT = 32'hFFFF_FFFF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ALU_OP_W-1:0] req_op_i,
  input  logic [DATA_W-1:0]   req_a_i,
  input  logic [DATA_W-1:0]   req_b_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  output logic [DATA_W-1:0]   alu_data1_o,
  output logic [DATA_W-1:0]   alu_data2_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                alu_zero_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_result_o,
  output logic                rsp_zero_o,
  output logic [TAG_W-1:0]    rsp_tag_o,
  output logic                rsp_err_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]         stat_issued_o,
  output logic [31:0]         stat_err_o
`endif
);

  localparam int unsigned I_W = $bits(issue_t) + TAG_W;
  localparam int unsigned R_W = $bits(resp_t) + TAG_W;

  issue_t             req_pl_c;
  issue_t             i_pl;
  logic [TAG_W-1:0]   i_tag;
  logic [I_W-1:0]     i_q;
  logic               i_valid;
  logic               i_in_ready_c;

  resp_t              r_pl_c;
  resp_t              r_pl;
  logic [R_W-1:0]     r_q;
  logic               r_in_ready_c;

  assign req_pl_c.op = req_op_i;
  assign req_pl_c.a  = req_a_i;
  assign req_pl_c.b  = req_b_i;

  // Combinational back-pressure from the response side, blocked during reset/flush
  assign req_ready_o = !flush_i & !rst_i & i_in_ready_c;

  pipe_stage #(.W(I_W)) u_stage_i (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .in_valid  (req_valid_i),
    .in_ready  (i_in_ready_c),
    .in_data   ({req_pl_c, req_tag_i}),
    .out_valid (i_valid),
    .out_ready (r_in_ready_c),
    .out_data  (i_q)
  );

  assign {i_pl, i_tag} = i_q;

  assign alu_data1_o = i_pl.a;
  assign alu_data2_o = i_pl.b;
  assign alu_op_o    = i_pl.op;

  // Screen illegal opcodes and divide-by-zero ahead of the response register
  always_comb begin
    r_pl_c.result = alu_result_i;
    r_pl_c.zero   = alu_zero_i;
    r_pl_c.err    = 1'b0;
    if (i_pl.op > OP_LAST) begin
      r_pl_c.err = 1'b1;
    end else if ((i_pl.op == DIV) && (i_pl.b == '0)) begin
      r_pl_c.err    = 1'b1;
      r_pl_c.result = DIV0_RESULT;
      r_pl_c.zero   = 1'b0;
    end
  end

  pipe_stage #(.W(R_W)) u_stage_r (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .in_valid  (i_valid),
    .in_ready  (r_in_ready_c),
    .in_data   ({r_pl_c, i_tag}),
    .out_valid (rsp_valid_o),
    .out_ready (rsp_ready_i),
    .out_data  (r_q)
  );

  assign {r_pl, rsp_tag_o} = r_q;

  assign rsp_result_o = r_pl.result;
  assign rsp_zero_o   = r_pl.zero;
  assign rsp_err_o    = r_pl.err;

`ifdef ALU_ISSUE_STATS_EN
  // Completed-response counters; a flushed response is discarded, not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_issued_o <= 32'd0;
      stat_err_o    <= 32'd0;
    end else if (rsp_valid_o & rsp_ready_i & !flush_i) begin
      stat_issued_o <= stat_issued_o + 32'd1;
      if (rsp_err_o) begin
        stat_err_o <= stat_err_o + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural ALU model.
// Build with ALU_ISSUE_STATS_EN defined to also check the counters.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [3:0]  req_tag_i;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic [3:0]  rsp_tag_o;
  logic        rsp_err_o;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued_o;
  logic [31:0] stat_err_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_issue dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tag_i    (req_tag_i),
    .alu_data1_o  (alu_data1_o),
    .alu_data2_o  (alu_data2_o),
    .alu_op_o     (alu_op_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_err_o    (rsp_err_o)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued_o(stat_issued_o),
    .stat_err_o   (stat_err_o)
`endif
  );

  // Behavioural combinational ALU (unknown opcodes return operand a)
  always_comb begin
    case (alu_op_o)
      ADD:     alu_result_i = alu_data1_o + alu_data2_o;
      SUB:     alu_result_i = alu_data1_o - alu_data2_o;
      MUL:     alu_result_i = alu_data1_o * alu_data2_o;
      DIV:     alu_result_i = (alu_data2_o == 32'd0) ? 32'd0 : alu_data1_o / alu_data2_o;
      AND:     alu_result_i = alu_data1_o & alu_data2_o;
      OR:      alu_result_i = alu_data1_o | alu_data2_o;
      XOR:     alu_result_i = alu_data1_o ^ alu_data2_o;
      NOT:     alu_result_i = ~alu_data1_o;
      LEZ:     alu_result_i = {31'd0, ($signed(alu_data1_o) <= 0)};
      LTZ:     alu_result_i = {31'd0, ($signed(alu_data1_o) < 0)};
      GTZ:     alu_result_i = {31'd0, ($signed(alu_data1_o) > 0)};
      EQT:     alu_result_i = {31'd0, (alu_data1_o == alu_data2_o)};
      NET:     alu_result_i = {31'd0, (alu_data1_o != alu_data2_o)};
      default: alu_result_i = alu_data1_o;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] res, input logic zero,
                           input logic [3:0] t, input logic err);
    check({tag, ".valid"},  64'(rsp_valid_o),  64'd1);
    check({tag, ".result"}, 64'(rsp_result_o), 64'(res));
    check({tag, ".zero"},   64'(rsp_zero_o),   64'(zero));
    check({tag, ".tag"},    64'(rsp_tag_o),    64'(t));
    check({tag, ".err"},    64'(rsp_err_o),    64'(err));
  endtask

  // One isolated op with rsp_ready held high; response checked after edge k+1
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] res, input logic zero, input logic err);
    drive(op, a, b, t);
    step();
    req_valid_i = 1'b0;
    step();
    check_rsp(tag, res, zero, t, err);
  endtask

  initial begin
    int idx;
    logic rdy;

    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    req_op_i = 4'h0; req_a_i = 32'd0; req_b_i = 32'd0; req_tag_i = 4'h0;

    // Reset state
    step();
    step();
    check("rst.req_ready", 64'(req_ready_o), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst.alu_op",    64'(alu_op_o),    64'd0);
    check("rst.alu_data1", 64'(alu_data1_o), 64'd0);
    check("rst.alu_data2", 64'(alu_data2_o), 64'd0);
    check("rst.result",    64'(rsp_result_o), 64'd0);
    check("rst.tag",       64'(rsp_tag_o),   64'd0);
    check("rst.err",       64'(rsp_err_o),   64'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst.req_ready", 64'(req_ready_o), 64'd1);

    // ADD 5+7 latency
    drive(ADD, 32'd5, 32'd7, 4'd3);
    step();
    check("add.alu_op",    64'(alu_op_o),    64'd0);
    check("add.alu_data1", 64'(alu_data1_o), 64'd5);
    check("add.alu_data2", 64'(alu_data2_o), 64'd7);
    check("add.rsp_early", 64'(rsp_valid_o), 64'd0);
    req_valid_i = 1'b0;
    step();
    check_rsp("add", 32'd12, 1'b0, 4'd3, 1'b0);

    // Back-to-back SUB, EQT, GTZ
    drive(SUB, 32'd9, 32'd9, 4'd1);
    step();
    check("b2b.ready1", 64'(req_ready_o), 64'd1);
    drive(EQT, 32'd4, 32'd4, 4'd2);
    step();
    check_rsp("b2b.sub", 32'd0, 1'b1, 4'd1, 1'b0);
    check("b2b.ready2", 64'(req_ready_o), 64'd1);
    drive(GTZ, 32'd0, 32'd0, 4'd3);
    step();
    check_rsp("b2b.eqt", 32'd1, 1'b0, 4'd2, 1'b0);
    check("b2b.ready3", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b0;
    step();
    check_rsp("b2b.gtz", 32'd0, 1'b1, 4'd3, 1'b0);
    step();
    check("b2b.drained", 64'(rsp_valid_o), 64'd0);

    // Stall: 5 cycles of rsp_ready low, 3 requests offered
    rsp_ready_i = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(ADD, 32'(idx + 1), 32'(idx + 1), 4'(4 + idx));
      rdy = req_ready_o;
      step();
      if (rdy) idx++;
      if (cyc >= 1) begin
        check("stall.hold_tag",    64'(rsp_tag_o),    64'd4);
        check("stall.hold_result", 64'(rsp_result_o), 64'd2);
      end
    end
    check("stall.accepted",  64'(idx), 64'd2);
    check("stall.req_ready", 64'(req_ready_o), 64'd0);
    check("stall.rsp_valid", 64'(rsp_valid_o), 64'd1);
    drive(ADD, 32'd3, 32'd3, 4'd6);
    rsp_ready_i = 1'b1;
    #1;
    check("release.req_ready", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    check_rsp("release.t5", 32'd4, 1'b0, 4'd5, 1'b0);
    step();
    check_rsp("release.t6", 32'd6, 1'b0, 4'd6, 1'b0);
    step();
    check("release.drained", 64'(rsp_valid_o), 64'd0);

    // Error screening
    single("div0", DIV, 32'd100, 32'd0, 4'd7, 32'hFFFF_FFFF, 1'b0, 1'b1);
    single("div7", DIV, 32'd100, 32'd7, 4'd8, 32'd14, 1'b0, 1'b0);
    single("ill_op", 4'hE, 32'h1234, 32'd5, 4'd9, 32'h1234, 1'b0, 1'b1);
    step();
    check("scr.drained", 64'(rsp_valid_o), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("stat.issued_pre", 64'(stat_issued_o), 64'd10);
    check("stat.err_pre",    64'(stat_err_o),    64'd2);
`endif

    // Flush with both stages full and a request pending
    rsp_ready_i = 1'b0;
    drive(ADD, 32'd1, 32'd2, 4'd10);
    step();
    drive(ADD, 32'd3, 32'd4, 4'd11);
    step();
    check("flush.rv_full", 64'(rsp_valid_o), 64'd1);
    drive(ADD, 32'd5, 32'd6, 4'd12);
    flush_i = 1'b1;
    #1;
    check("flush.req_ready", 64'(req_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush.rsp_valid", 64'(rsp_valid_o), 64'd0);
    rsp_ready_i = 1'b1;
    step();
    check("flush.no_late_rsp", 64'(rsp_valid_o), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("stat.issued_flush", 64'(stat_issued_o), 64'd10);
    check("stat.err_flush",    64'(stat_err_o),    64'd2);
`endif

    // Reset mid-operation drops the in-flight op
    drive(ADD, 32'd8, 32'd8, 4'd13);
    step();
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst.alu_data1", 64'(alu_data1_o), 64'd0);
    step();
    check("midrst.no_rsp", 64'(rsp_valid_o), 64'd0);

    // Three good ops and one error after reset
    single("post.mul", MUL, 32'd6, 32'd7, 4'd1, 32'd42, 1'b0, 1'b0);
    single("post.xor", XOR, 32'hF0, 32'hF0, 4'd2, 32'd0, 1'b1, 1'b0);
    single("post.ltz", LTZ, 32'hFFFF_FFFF, 32'd0, 4'd3, 32'd1, 1'b0, 1'b0);
    single("post.div0", DIV, 32'd1, 32'd0, 4'd4, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step();
`ifdef ALU_ISSUE_STATS_EN
    check("stat.issued_post", 64'(stat_issued_o), 64'd4);
    check("stat.err_post",    64'(stat_err_o),    64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
